// File: rtl/jg3_arbiter.sv
// jg3_arbiter: round-robin arbiter that shares one combinational JG3 decoder
// between three requesters. The winner's operand is latched, held on ABC for
// SETTLE cycles, and the decoder response (X, Y) is then captured and returned
// with a one-cycle ack pulse. An X=1/Y=1 response is physically impossible for
// a healthy decoder and raises a sticky error flag.
module jg3_arbiter #(
    parameter int unsigned SETTLE = 32'd1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic [8:0] req_abc,
    output logic [2:0] ABC,
    input  logic       X,
    input  logic       Y,
    output logic [2:0] gnt,
    output logic [2:0] ack,
    output logic       res_x,
    output logic       res_y,
    output logic       busy,
    output logic       err
);

    // Last DRIVE cycle index; cnt is 2 bits so SETTLE is limited to 1..4.
    localparam logic [1:0] SETTLE_LAST = 2'(SETTLE - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t     r_state;
    logic [1:0] r_cnt;
    logic [1:0] r_last;
    logic [1:0] r_win;
    logic [2:0] r_abc;
    logic [2:0] r_gnt;
    logic [2:0] r_ack;
    logic       r_res_x;
    logic       r_res_y;
    logic       r_busy;
    logic       r_err;

    logic [1:0] w_pick;
    logic [2:0] w_opnd;

    // Next index in the 0 -> 1 -> 2 -> 0 rotation.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        case (idx)
            2'd0:    rr_next = 2'd1;
            2'd1:    rr_next = 2'd2;
            default: rr_next = 2'd0;
        endcase
    endfunction

    // Request bit of requester idx.
    function automatic logic req_bit(input logic [2:0] r, input logic [1:0] idx);
        case (idx)
            2'd0:    req_bit = r[0];
            2'd1:    req_bit = r[1];
            2'd2:    req_bit = r[2];
            default: req_bit = 1'b0;
        endcase
    endfunction

    // One-hot vector for requester idx.
    function automatic logic [2:0] onehot(input logic [1:0] idx);
        case (idx)
            2'd0:    onehot = 3'b001;
            2'd1:    onehot = 3'b010;
            2'd2:    onehot = 3'b100;
            default: onehot = 3'b000;
        endcase
    endfunction

    // First requesting index scanning from (last+1) mod 3; only meaningful when r != 0.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
        logic [1:0] p0;
        logic [1:0] p1;
        logic [1:0] p2;
        p0 = rr_next(last);
        p1 = rr_next(p0);
        p2 = rr_next(p1);
        if (req_bit(r, p0)) begin
            rr_pick = p0;
        end else if (req_bit(r, p1)) begin
            rr_pick = p1;
        end else begin
            rr_pick = p2;
        end
    endfunction

    // Round-robin winner and its operand slice for the current request vector.
    always_comb begin
        w_pick = rr_pick(req, r_last);
        case (w_pick)
            2'd0:    w_opnd = req_abc[2:0];
            2'd1:    w_opnd = req_abc[5:3];
            2'd2:    w_opnd = req_abc[8:6];
            default: w_opnd = 3'b000;
        endcase
    end

    // Transaction FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 2'd0;
            r_last  <= 2'd2;
            r_win   <= 2'd0;
            r_abc   <= 3'b000;
            r_gnt   <= 3'b000;
            r_ack   <= 3'b000;
            r_res_x <= 1'b0;
            r_res_y <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ack <= 3'b000;
                    r_cnt <= 2'd0;
                    if (req != 3'b000) begin
                        r_win   <= w_pick;
                        r_gnt   <= onehot(w_pick);
                        r_abc   <= w_opnd;
                        r_busy  <= 1'b1;
                        r_state <= ST_DRIVE;
                    end else begin
                        r_gnt  <= 3'b000;
                        r_abc  <= 3'b000;
                        r_busy <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    if (r_cnt == SETTLE_LAST) begin
                        r_res_x <= X;
                        r_res_y <= Y;
                        if (X && Y) begin
                            r_err <= 1'b1;
                        end else begin
                            r_err <= r_err;
                        end
                        r_cnt   <= 2'd0;
                        r_ack   <= onehot(r_win);
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                ST_RESP: begin
                    // Returning through IDLE guarantees at least one idle cycle.
                    r_ack   <= 3'b000;
                    r_last  <= r_win;
                    r_gnt   <= 3'b000;
                    r_abc   <= 3'b000;
                    r_busy  <= 1'b0;
                    r_cnt   <= 2'd0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_ack   <= 3'b000;
                    r_gnt   <= 3'b000;
                    r_abc   <= 3'b000;
                    r_busy  <= 1'b0;
                    r_cnt   <= 2'd0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ABC   = r_abc;
    assign gnt   = r_gnt;
    assign ack   = r_ack;
    assign res_x = r_res_x;
    assign res_y = r_res_y;
    assign busy  = r_busy;
    assign err   = r_err;

endmodule

// File: tb/tb_jg3_arbiter.sv
// Bench for jg3_arbiter: two instances (SETTLE=1 and SETTLE=3) share stimulus;
// one is selected at a time and checked against a transaction-level model
// through a scoreboard queue popped by an independent monitor.
module tb_jg3_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] req;
    logic [8:0] req_abc;
    logic       inject;
    logic       sel;
    logic [2:0] hold_mask;

    logic [2:0] abc_1, gnt_1, ack_1;
    logic       x_1, y_1, rx_1, ry_1, busy_1, err_1;
    logic [2:0] abc_3, gnt_3, ack_3;
    logic       x_3, y_3, rx_3, ry_3, busy_3, err_3;

    logic [2:0] w_abc, w_gnt, w_ack;
    logic       w_rx, w_ry, w_busy, w_err;

    always #5 clk = ~clk;

    // Decoder stubs: JG3 behaviour, or forced X=Y=1 when injecting a fault.
    assign x_1 = inject | (abc_1 >= 3'd5);
    assign y_1 = inject | (abc_1 == 3'd0);
    assign x_3 = inject | (abc_3 >= 3'd5);
    assign y_3 = inject | (abc_3 == 3'd0);

    jg3_arbiter #(.SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .req_abc(req_abc), .ABC(abc_1),
        .X(x_1), .Y(y_1), .gnt(gnt_1), .ack(ack_1), .res_x(rx_1), .res_y(ry_1),
        .busy(busy_1), .err(err_1)
    );

    jg3_arbiter #(.SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req(req), .req_abc(req_abc), .ABC(abc_3),
        .X(x_3), .Y(y_3), .gnt(gnt_3), .ack(ack_3), .res_x(rx_3), .res_y(ry_3),
        .busy(busy_3), .err(err_3)
    );

    assign w_abc  = sel ? abc_3  : abc_1;
    assign w_gnt  = sel ? gnt_3  : gnt_1;
    assign w_ack  = sel ? ack_3  : ack_1;
    assign w_rx   = sel ? rx_3   : rx_1;
    assign w_ry   = sel ? ry_3   : ry_1;
    assign w_busy = sel ? busy_3 : busy_1;
    assign w_err  = sel ? err_3  : err_1;

    typedef struct {
        logic [2:0] ack;
        logic       x;
        logic       y;
        logic       e;
        int         cyc;
    } exp_t;

    exp_t sb_q[$];

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Reference model state: transaction-level view of the arbiter.
    int         m_wait = 0;
    int         m_last = 2;
    logic       m_err  = 1'b0;
    logic [2:0] m_gnt  = 3'b000;

    // Free-running posedge counter used to time-stamp expected acks.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d, settle sel %0d)", name, act, exp, cyc, sel);
        end
    endtask

    // Advance the model by one rising edge using the inputs just driven.
    task automatic model_step();
        int settle;
        int w;
        logic [2:0] op;
        exp_t e;
        settle = sel ? 3 : 1;
        if (!rst_n) begin
            sb_q.delete();
            m_wait = 0;
            m_last = 2;
            m_err  = 1'b0;
            m_gnt  = 3'b000;
        end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) m_gnt = 3'b000;
        end else if (req != 3'b000) begin
            w = -1;
            for (int k = 1; k <= 3; k++) begin
                int idx;
                idx = (m_last + k) % 3;
                if (w < 0 && req[idx]) w = idx;
            end
            op     = req_abc[3*w +: 3];
            e.ack  = 3'b001 << w;
            e.x    = inject ? 1'b1 : (op >= 3'd5);
            e.y    = inject ? 1'b1 : (op == 3'd0);
            m_err  = m_err | inject;
            e.e    = m_err;
            e.cyc  = cyc + 1 + settle;
            sb_q.push_back(e);
            m_last = w;
            m_gnt  = e.ack;
            m_wait = settle + 1;
        end else begin
            m_gnt = 3'b000;
        end
    endtask

    // Requesters release their request after seeing their ack.
    task automatic edge_prep();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            if (w_ack[i] && !hold_mask[i]) req[i] = 1'b0;
        end
    endtask

    task automatic run(input int n, input bit rnd);
        repeat (n) begin
            edge_prep();
            if (rnd) begin
                for (int i = 0; i < 3; i++) begin
                    if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
                    else if (req[i] && m_gnt[i] && $urandom_range(0, 15) == 0) req[i] = 1'b0;
                end
                req_abc = 9'($urandom);
            end
            model_step();
        end
    endtask

    task automatic reset_dut();
        edge_prep();
        rst_n     = 1'b0;
        req       = 3'b000;
        hold_mask = 3'b000;
        inject    = 1'b0;
        model_step();
        #1;
        chk("rst_abc",  32'(w_abc),  32'd0);
        chk("rst_gnt",  32'(w_gnt),  32'd0);
        chk("rst_ack",  32'(w_ack),  32'd0);
        chk("rst_resx", 32'(w_rx),   32'd0);
        chk("rst_resy", 32'(w_ry),   32'd0);
        chk("rst_busy", 32'(w_busy), 32'd0);
        chk("rst_err",  32'(w_err),  32'd0);
        run(2, 1'b0);
        edge_prep();
        rst_n = 1'b1;
        model_step();
    endtask

    // Monitor: per-cycle grant/busy checks and scoreboard pop on every ack.
    always @(posedge clk) begin
        exp_t e;
        #1;
        chk("gnt",  32'(w_gnt),  32'(m_gnt));
        chk("busy", 32'(w_busy), 32'(m_gnt != 3'b000));
        if (w_ack != 3'b000) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_ack", 32'(w_ack), 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("ack",       32'(w_ack), 32'(e.ack));
                chk("ack_cycle", 32'(cyc),   32'(e.cyc));
                chk("res_x",     32'(w_rx),  32'(e.x));
                chk("res_y",     32'(w_ry),  32'(e.y));
                chk("err",       32'(w_err), 32'(e.e));
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        req       = 3'b000;
        req_abc   = 9'd0;
        inject    = 1'b0;
        sel       = 1'b0;
        hold_mask = 3'b000;

        // SETTLE=1: reset, then idle with no requests.
        reset_dut();
        run(3, 1'b0);

        // Single request, operand 000 -> X=0, Y=1.
        edge_prep();
        req = 3'b001; req_abc = 9'b000_000_000;
        model_step();
        run(5, 1'b0);

        // Simultaneous requests from reset priority.
        reset_dut();
        edge_prep();
        req = 3'b111; req_abc = {3'b000, 3'b011, 3'b101};
        model_step();
        run(12, 1'b0);

        // Fairness: both requests held high keep alternating.
        reset_dut();
        edge_prep();
        hold_mask = 3'b011; req = 3'b011; req_abc = 9'b000_110_001;
        model_step();
        run(12, 1'b0);
        edge_prep();
        hold_mask = 3'b000; req = 3'b000;
        model_step();
        run(4, 1'b0);

        // Error injection: err set, ack still issued, err sticky afterwards.
        edge_prep();
        inject = 1'b1; req = 3'b100; req_abc = 9'b010_000_000;
        model_step();
        run(4, 1'b0);
        edge_prep();
        inject = 1'b0; req = 3'b010; req_abc = 9'b000_111_000;
        model_step();
        run(4, 1'b0);
        chk("err_sticky", 32'(w_err), 32'd1);
        reset_dut();
        chk("err_cleared", 32'(w_err), 32'd0);

        // Randomized traffic with operands changing under the grant.
        run(300, 1'b1);

        // SETTLE=3 instance.
        sel = 1'b1;
        reset_dut();

        // Abort: reset during the second DRIVE cycle, then re-arbitrate.
        edge_prep();
        req = 3'b010; req_abc = 9'b000_101_000;
        model_step();
        run(1, 1'b0);
        edge_prep();
        rst_n = 1'b0;
        #1;
        chk("abort_gnt",  32'(w_gnt),  32'd0);
        chk("abort_busy", 32'(w_busy), 32'd0);
        chk("abort_ack",  32'(w_ack),  32'd0);
        model_step();
        edge_prep();
        rst_n = 1'b1;
        model_step();
        run(8, 1'b0);

        // Randomized traffic at SETTLE=3.
        run(300, 1'b1);

        edge_prep();
        req = 3'b000;
        model_step();
        run(10, 1'b0);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
